// File: rtl/buzzer_pkg.sv
// -----------------------------------------------------------------------------
// buzzer_pkg
// Shared types and helpers for the four-player buzzer arbiter.
//   NUM_PLAYERS  : number of player slots (4)
//   player_id_t  : 2-bit player index
//   state_t      : round sequencer states IDLE / ARMED / CAPTURED / RELEASE
//   grant_t      : result of the rotating-priority pick (valid + id)
//   rotate_pick  : picks the highest-priority requester, starting at ptr
// -----------------------------------------------------------------------------
package buzzer_pkg;

  localparam int NUM_PLAYERS = 4;

  typedef logic [1:0] player_id_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    CAPTURED = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    player_id_t id;
  } grant_t;

  // Priority order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The loop walks from
  // the lowest-priority slot up to ptr, so the last hit is the winner and no
  // early exit is needed.
  function automatic grant_t rotate_pick(input logic [NUM_PLAYERS-1:0] req,
                                         input player_id_t ptr);
    grant_t     g;
    player_id_t idx;
    g.valid = 1'b0;
    g.id    = ptr;
    for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
      idx = ptr + player_id_t'(k);
      if (req[idx]) begin
        g.valid = 1'b1;
        g.id    = idx;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// -----------------------------------------------------------------------------
// lockout_timer
// Per-player early-press penalty timer. A load pulse (re)starts the count at
// LOCKOUT_CYCLES; the count then runs down to zero by one per cycle.
//   clk     in  system clock
//   reset   in  synchronous active-high reset, clears the count
//   load    in  restart the penalty (a new early press)
//   active  out high while the count is nonzero
// -----------------------------------------------------------------------------
module lockout_timer #(
  parameter int unsigned LOCKOUT_CYCLES = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic active
);

  localparam int unsigned CNT_W = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(LOCKOUT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active = (cnt_q != '0);

endmodule

// File: rtl/buzzer_arbiter.sv
// -----------------------------------------------------------------------------
// buzzer_arbiter
// Round sequencer and first-press arbiter for four player controllers. The CPU
// arms a round, the first eligible press edge wins (rotating priority on ties),
// the winner's switch byte is latched and held until ack, then the block waits
// for a clean all-released cooldown before it can be armed again.
//
// Optional feature: define BUZZER_LOCKOUT_EN to build per-player early-press
// penalty timers (a press edge while IDLE locks that player out for
// LOCKOUT_CYCLES cycles). Without the macro lockedOut is tied to 0.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   arm          in   pulse: open a round (honoured only in IDLE)
//   ack          in   pulse: consume the winner (honoured only in CAPTURED)
//   btn[3:0]     in   debounced buttons, bit i = player i
//   sw[31:0]     in   switch banks, sw[8i+7:8i] = player i
//   armed        out  high while ARMED
//   winnerValid  out  high while CAPTURED
//   winnerId     out  last captured player (held until next capture)
//   winnerSw     out  winner's switches sampled on the press cycle
//   lockedOut    out  per-player penalty active
// -----------------------------------------------------------------------------
module buzzer_arbiter
  import buzzer_pkg::*;
#(
  parameter int unsigned COOLDOWN_CYCLES = 50000,
  parameter int unsigned LOCKOUT_CYCLES  = 25000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   ack,
  input  logic [NUM_PLAYERS-1:0] btn,
  input  logic [31:0]            sw,
  output logic                   armed,
  output logic                   winnerValid,
  output logic [1:0]             winnerId,
  output logic [7:0]             winnerSw,
  output logic [NUM_PLAYERS-1:0] lockedOut
);

  localparam int unsigned CNT_W = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                 state_q,     state_d;
  logic [NUM_PLAYERS-1:0] btn_q;
  player_id_t             ptr_q,       ptr_d;
  player_id_t             winner_id_q, winner_id_d;
  logic [7:0]             winner_sw_q, winner_sw_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;

  // ---------------------------------------------------------------------------
  // Press detection and arbitration
  // ---------------------------------------------------------------------------
  logic [NUM_PLAYERS-1:0] press_edge;
  logic [NUM_PLAYERS-1:0] locked;
  logic [NUM_PLAYERS-1:0] eligible;
  grant_t                 grant;
  logic [7:0]             sw_bank [NUM_PLAYERS];

  // btn_q resets to all ones, so a button held through reset shows no edge
  // until it has been released and pressed again.
  assign press_edge = btn & ~btn_q;
  assign eligible   = press_edge & ~locked;
  assign grant      = rotate_pick(eligible, ptr_q);

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_sw_bank
    assign sw_bank[gi] = sw[8*gi +: 8];
  end

  // ---------------------------------------------------------------------------
  // Optional early-press lockout
  // ---------------------------------------------------------------------------
`ifdef BUZZER_LOCKOUT_EN
  logic [NUM_PLAYERS-1:0] early_press;

  // Only presses made before the round is open count as early; the timers
  // themselves keep running in every state.
  assign early_press = (state_q == IDLE) ? press_edge : '0;

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_lockout
    lockout_timer #(
      .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (early_press[gi]),
      .active(locked[gi])
    );
  end
`else
  logic unused_lockout_cycles;

  assign locked                = '0;
  assign unused_lockout_cycles = ^LOCKOUT_CYCLES;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      btn_q       <= '1;
      ptr_q       <= '0;
      winner_id_q <= '0;
      winner_sw_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn;
      ptr_q       <= ptr_d;
      winner_id_q <= winner_id_d;
      winner_sw_q <= winner_sw_d;
      cnt_q       <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    winner_id_d = winner_id_q;
    winner_sw_d = winner_sw_q;
    cnt_d       = cnt_q;

    // Each case looks only at the command that is meaningful in that state,
    // so arm and ack together are resolved by the current state.
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
        end
      end

      ARMED: begin
        if (grant.valid) begin
          state_d     = CAPTURED;
          winner_id_d = grant.id;
          winner_sw_d = sw_bank[grant.id];
          // The slot after the winner gets top priority next round.
          ptr_d       = grant.id + player_id_t'(1);
        end
      end

      CAPTURED: begin
        if (ack) begin
          state_d = RELEASE;
          cnt_d   = CNT_W'(COOLDOWN_CYCLES);
        end
      end

      RELEASE: begin
        // Any held button restarts the cooldown; the round ends only after
        // COOLDOWN_CYCLES consecutive all-released cycles.
        if (btn != '0) begin
          cnt_d = CNT_W'(COOLDOWN_CYCLES);
        end else if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    armed       = (state_q == ARMED);
    winnerValid = (state_q == CAPTURED);
    winnerId    = winner_id_q;
    winnerSw    = winner_sw_q;
    lockedOut   = locked;
  end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_buzzer_arbiter
// Directed, table-driven bench for buzzer_arbiter with COOLDOWN_CYCLES = 4 and
// LOCKOUT_CYCLES = 8. Each vector drives one cycle of inputs and gives the
// outputs expected after that clock edge. Hand-written sequences follow for
// cooldown restart, reset mid-round with held buttons, and early-press lockout.
// -----------------------------------------------------------------------------
module tb_buzzer_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic        ack;
  logic [3:0]  btn;
  logic [31:0] sw;
  logic        armed;
  logic        winnerValid;
  logic [1:0]  winnerId;
  logic [7:0]  winnerSw;
  logic [3:0]  lockedOut;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] SW_A = 32'h33A5_7711;

  typedef struct {
    logic        arm;
    logic        ack;
    logic [3:0]  btn;
    logic [31:0] sw;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  buzzer_arbiter #(
    .COOLDOWN_CYCLES(4),
    .LOCKOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .ack        (ack),
    .btn        (btn),
    .sw         (sw),
    .armed      (armed),
    .winnerValid(winnerValid),
    .winnerId   (winnerId),
    .winnerSw   (winnerSw),
    .lockedOut  (lockedOut)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ex(input logic a, input logic v, input logic [1:0] id,
                                     input logic [7:0] s, input logic [3:0] lo);
    return {a, v, id, s, lo};
  endfunction

  task automatic chk(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = {armed, winnerValid, winnerId, winnerSw, lockedOut};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: armed/valid/id/sw/lock got %0b/%0b/%0d/%02h/%04b required %0b/%0b/%0d/%02h/%04b",
               name, act[15], act[14], act[13:12], act[11:4], act[3:0],
               exp[15], exp[14], exp[13:12], exp[11:4], exp[3:0]);
    end else begin
      $display("ok   %s: armed/valid/id/sw/lock %0b/%0b/%0d/%02h/%04b",
               name, act[15], act[14], act[13:12], act[11:4], act[3:0]);
    end
  endtask

  // Apply inputs for one clock edge; returns on the following falling edge.
  task automatic drive(input logic a, input logic k, input logic [3:0] b, input logic [31:0] s);
    arm = a;
    ack = k;
    btn = b;
    sw  = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic a, input logic k, input logic [3:0] b, input logic [31:0] s,
                     input logic [15:0] e);
    vec_t v;
    v.arm = a;
    v.ack = k;
    v.btn = b;
    v.sw  = s;
    v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0]  lo;
    logic [1:0]  late_id;
    logic [7:0]  late_sw;
    logic        late_armed;

    // ---------------- vector table ----------------
    add(0, 0, 4'h0, SW_A, ex(0, 0, 0, 8'h00, 0));   // 0 idle
    add(1, 0, 4'h0, SW_A, ex(1, 0, 0, 8'h00, 0));   // 1 arm
    add(0, 0, 4'h4, SW_A, ex(0, 1, 2, 8'hA5, 0));   // 2 single press, player 2
    add(0, 0, 4'h0, SW_A, ex(0, 1, 2, 8'hA5, 0));   // 3 hold
    add(0, 1, 4'h0, SW_A, ex(0, 0, 2, 8'hA5, 0));   // 4 ack
    add(0, 0, 4'h0, SW_A, ex(0, 0, 2, 8'hA5, 0));   // 5 cooldown 3
    add(0, 0, 4'h0, SW_A, ex(0, 0, 2, 8'hA5, 0));   // 6 cooldown 2
    add(0, 0, 4'h0, SW_A, ex(0, 0, 2, 8'hA5, 0));   // 7 cooldown 1
    add(1, 0, 4'h0, SW_A, ex(0, 0, 2, 8'hA5, 0));   // 8 arm ignored, last RELEASE cycle
    add(1, 0, 4'h0, SW_A, ex(1, 0, 2, 8'hA5, 0));   // 9 arm accepted
    add(0, 0, 4'hF, SW_A, ex(0, 1, 3, 8'h33, 0));   // 10 tie, ptr 3
    add(1, 1, 4'hF, SW_A, ex(0, 0, 3, 8'h33, 0));   // 11 arm+ack in CAPTURED -> ack
    add(0, 0, 4'hF, SW_A, ex(0, 0, 3, 8'h33, 0));   // 12 held -> reload
    add(0, 0, 4'h0, SW_A, ex(0, 0, 3, 8'h33, 0));   // 13
    add(0, 0, 4'h0, SW_A, ex(0, 0, 3, 8'h33, 0));   // 14
    add(0, 0, 4'h0, SW_A, ex(0, 0, 3, 8'h33, 0));   // 15
    add(1, 0, 4'h0, SW_A, ex(0, 0, 3, 8'h33, 0));   // 16 arm ignored
    add(1, 0, 4'h0, SW_A, ex(1, 0, 3, 8'h33, 0));   // 17 arm
    add(0, 1, 4'h0, SW_A, ex(1, 0, 3, 8'h33, 0));   // 18 ack in ARMED ignored
    add(0, 0, 4'hF, SW_A, ex(0, 1, 0, 8'h11, 0));   // 19 tie, ptr 0
    add(1, 0, 4'hF, SW_A, ex(0, 1, 0, 8'h11, 0));   // 20 arm in CAPTURED ignored
    add(0, 0, 4'h0, SW_A, ex(0, 1, 0, 8'h11, 0));   // 21
    add(0, 0, 4'h2, SW_A, ex(0, 1, 0, 8'h11, 0));   // 22 late press ignored
    add(0, 1, 4'h0, SW_A, ex(0, 0, 0, 8'h11, 0));   // 23 ack
    add(0, 0, 4'h0, SW_A, ex(0, 0, 0, 8'h11, 0));   // 24
    add(0, 0, 4'h0, SW_A, ex(0, 0, 0, 8'h11, 0));   // 25
    add(0, 0, 4'h0, SW_A, ex(0, 0, 0, 8'h11, 0));   // 26
    add(1, 0, 4'h0, SW_A, ex(0, 0, 0, 8'h11, 0));   // 27 arm ignored
    add(1, 0, 4'h0, SW_A, ex(1, 0, 0, 8'h11, 0));   // 28 arm
    add(0, 0, 4'hF, SW_A, ex(0, 1, 1, 8'h77, 0));   // 29 tie, ptr 1
    add(0, 0, 4'hF, 32'h0, ex(0, 1, 1, 8'h77, 0));  // 30 switches change, winnerSw holds
    add(0, 1, 4'h0, SW_A, ex(0, 0, 1, 8'h77, 0));   // 31 ack, id holds
    add(0, 0, 4'h0, SW_A, ex(0, 0, 1, 8'h77, 0));   // 32
    add(0, 0, 4'h0, SW_A, ex(0, 0, 1, 8'h77, 0));   // 33
    add(0, 0, 4'h0, SW_A, ex(0, 0, 1, 8'h77, 0));   // 34
    add(0, 0, 4'h0, SW_A, ex(0, 0, 1, 8'h77, 0));   // 35 -> IDLE
    add(1, 0, 4'h0, SW_A, ex(1, 0, 1, 8'h77, 0));   // 36 arm, ptr 2

    // ---------------- reset ----------------
    reset = 1'b1;
    arm   = 1'b0;
    ack   = 1'b0;
    btn   = 4'h0;
    sw    = SW_A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", ex(0, 0, 0, 8'h00, 0));
    reset = 1'b0;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      drive(vecs[i].arm, vecs[i].ack, vecs[i].btn, vecs[i].sw);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // ---------------- cooldown restart (ARMED, ptr 2) ----------------
    drive(0, 0, 4'h4, SW_A);
    chk("cd_capture", ex(0, 1, 2, 8'hA5, 0));
    drive(0, 1, 4'h0, SW_A);
    chk("cd_ack", ex(0, 0, 2, 8'hA5, 0));
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 4'h1, SW_A);
      chk($sformatf("cd_hold%0d", i), ex(0, 0, 2, 8'hA5, 0));
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 4'h0, SW_A);
      chk($sformatf("cd_gap%0d", i), ex(0, 0, 2, 8'hA5, 0));
    end
    drive(1, 0, 4'h1, SW_A);
    chk("cd_repress", ex(0, 0, 2, 8'hA5, 0));
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 4'h0, SW_A);
      chk($sformatf("cd_clean%0d", i), ex(0, 0, 2, 8'hA5, 0));
    end
    drive(1, 0, 4'h0, SW_A);
    chk("cd_rearm", ex(1, 0, 2, 8'hA5, 0));

    // ---------------- reset mid-round, button held (ARMED, ptr 3) ----------------
    drive(0, 0, 4'h4, SW_A);
    chk("rst_capture", ex(0, 1, 2, 8'hA5, 0));
    reset = 1'b1;
    drive(0, 0, 4'h4, SW_A);
    chk("rst_clear", ex(0, 0, 0, 8'h00, 0));
    reset = 1'b0;
    drive(0, 0, 4'h4, SW_A);
    chk("rst_idle_held", ex(0, 0, 0, 8'h00, 0));
    drive(1, 0, 4'h4, SW_A);
    chk("rst_arm_held", ex(1, 0, 0, 8'h00, 0));
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 4'h4, SW_A);
      chk($sformatf("rst_still_held%0d", i), ex(1, 0, 0, 8'h00, 0));
    end
    drive(0, 0, 4'h0, SW_A);
    chk("rst_released", ex(1, 0, 0, 8'h00, 0));
    drive(0, 0, 4'hF, SW_A);
    chk("rst_ptr_zero_tie", ex(0, 1, 0, 8'h11, 0));
    drive(0, 1, 4'h0, SW_A);
    chk("rst_ack", ex(0, 0, 0, 8'h11, 0));
    repeat (4) drive(0, 0, 4'h0, SW_A);

    // ---------------- early press / lockout (IDLE, ptr 1) ----------------
`ifdef BUZZER_LOCKOUT_EN
    lo         = 4'b1000;
    late_id    = 2'd1;
    late_sw    = 8'h77;
    late_armed = 1'b1;
`else
    lo         = 4'b0000;
    late_id    = 2'd3;
    late_sw    = 8'h33;
    late_armed = 1'b0;
`endif
    drive(0, 0, 4'h8, SW_A);
    chk("lo_early_press", ex(0, 0, 0, 8'h11, lo));
    drive(1, 0, 4'h0, SW_A);
    chk("lo_arm", ex(1, 0, 0, 8'h11, lo));
    drive(0, 0, 4'h8, SW_A);
    if (late_armed) chk("lo_p3_press", ex(1, 0, 0, 8'h11, lo));
    else            chk("lo_p3_press", ex(0, 1, 3, 8'h33, lo));
    drive(0, 0, 4'hA, SW_A);
    chk("lo_p1_press", ex(0, 1, late_id, late_sw, lo));
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 4'hA, SW_A);
      chk($sformatf("lo_count%0d", i), ex(0, 1, late_id, late_sw, lo));
    end
    drive(0, 0, 4'hA, SW_A);
    chk("lo_expired", ex(0, 1, late_id, late_sw, 4'b0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buzzer_arbiter.md
# buzzer_arbiter

Round sequencer and first-press arbiter for the four player controllers. It sits between the per-player debounced buttons and switch banks and the CPU-facing input register. The CPU arms a round. The block captures exactly one winner, latches that player's 8-bit switch value, and holds it until acknowledged. It then waits for all buttons to be released before it can be armed again. Simultaneous presses are resolved by a rotating-priority tie-break, so no player slot is permanently favoured.

## Interface
- COOLDOWN_CYCLES, default 50000: clean cycles with all buttons released that are required after ack (1 ms at 50 MHz).
- LOCKOUT_CYCLES, default 25000000: early-press penalty length in cycles (0.5 s); used only with the macro.
- clk  in  1  system clock, 50 MHz; single clock domain.
- reset  in  1  synchronous, active-high.
- arm  in  1  single-cycle pulse from the CPU that opens a round.
- ack  in  1  single-cycle pulse from the CPU that consumes the winner.
- btn  in  4  debounced buttons, active-high; bit i is player i.
- sw  in  32  player switch banks; sw[8i+7:8i] belongs to player i.
- armed  out  1  high while in ARMED.
- winnerValid  out  1  high while in CAPTURED.
- winnerId  out  2  winning player; holds its value until the next capture.
- winnerSw  out  8  that player's switches, sampled on the press cycle.
- lockedOut  out  4  per-player penalty active.

## Operation
- States:
  - IDLE → ARMED on arm.
  - ARMED → CAPTURED on any eligible press edge.
  - CAPTURED → RELEASE on ack.
  - RELEASE → IDLE when the cooldown counter expires.
- Press edge: btn & ~btn_q, where btn_q is the registered btn. btn_q resets to 4'b1111, so a button held through reset never produces an edge.
- Eligible press: the press edge for player i with lockedOut[i] = 0.
- Tie-break: a 2-bit pointer ptr names the highest-priority player. Priority order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- On capture: ptr ← winnerId + 1 (mod 4), wrapping 3→0. Winner, winnerSw, and the state update in the same cycle.
- RELEASE: the counter loads COOLDOWN_CYCLES on entry. It decrements while btn == 0 and reloads on any btn bit high. On reaching 0 the state moves to IDLE.
- Counter width is $clog2(COOLDOWN_CYCLES+1).
- arm outside IDLE is ignored. ack outside CAPTURED is ignored.
- A press in the same cycle as arm (state still IDLE) is not eligible.
- arm and ack asserted together are resolved by the current state only.
- Presses in CAPTURED or RELEASE are ignored, apart from restarting the cooldown.

## Timing
- Reset values: state IDLE, armed 0, winnerValid 0, winnerId 0, winnerSw 0, lockedOut 0, ptr 0, counters 0.
- arm accepted at cycle N → armed = 1 at N+1.
- btn rises at cycle N while ARMED → btn_q differs at N → winnerValid, winnerId, winnerSw valid at N+1. winnerSw reflects sw at cycle N.
- ack at cycle N → winnerValid = 0 at N+1.
- Minimum RELEASE duration is COOLDOWN_CYCLES cycles.
- Reset asserted mid-round: every register returns to its reset value on the next edge, and any in-flight round is discarded.

## Configuration
- BUZZER_LOCKOUT_EN defined:
  - A press edge by player i while in IDLE loads that player's timer with LOCKOUT_CYCLES.
  - lockedOut[i] = 1 while the timer is nonzero.
  - Presses from a locked player are not eligible in ARMED.
  - A new early press reloads the timer.
  - Timers count in every state.
- BUZZER_LOCKOUT_EN undefined: early presses have no effect, lockedOut is tied to 0, and no timers are built.

## Structure
- Package buzzer_pkg holds:
  - NUM_PLAYERS = 4;
  - the player_id_t 2-bit typedef;
  - the state enum: IDLE, ARMED, CAPTURED, RELEASE.
- Sub-module lockout_timer: load, count-down, and nonzero flag, parameterised by LOCKOUT_CYCLES. It is instantiated per player only under BUZZER_LOCKOUT_EN.

## Test plan
Bench parameters: COOLDOWN_CYCLES = 4, LOCKOUT_CYCLES = 8.
- Single press: reset, arm, then btn = 4'b0100 with sw[23:16] = 8'hA5 → one cycle later winnerValid = 1, winnerId = 2, winnerSw = 8'hA5.
- Tie rotation: with ptr = 0, btn = 4'b1111 → winnerId = 0. Release, then ack; after 4 clean cycles arm again, then btn = 4'b1111 → winnerId = 1.
- Ignored commands and late press: ack while ARMED and arm while CAPTURED → no state change. A second player pressing during CAPTURED → winnerId unchanged.
- Cooldown restart: after ack, hold btn[0] for 3 cycles, release for 2, press again, then release → IDLE only after 4 consecutive cycles with btn = 0.
- Lockout (macro on): player 3 presses in IDLE → lockedOut = 4'b1000 for 8 cycles. Arm immediately; a player-3 press is ignored and a player-1 press is captured.
- Reset and held buttons: reset asserted during CAPTURED → all outputs 0 next cycle. btn held high through reset, then arm → no capture until the button is released and pressed again.
